// File: rtl/fifo_pkg.sv
// Shared constants and pointer-encoding helpers for the pixel-path FIFO.
package fifo_pkg;

    localparam int DATA_SIZE_DEF = 32;
    localparam int ADDR_SIZE_DEF = 8;

    // Binary to reflected Gray code; callers zero-extend narrower pointers.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ {1'b0, bin[31:1]};
    endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop pointer synchronizer; kept as its own block so it can move into
// the destination domain unchanged once the FIFO is split across clocks.
module fifo_sync_2ff #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the foreign-side Gray pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/async_fifo_core.sv
// Gray-pointer FIFO with synchronized flags, single clock today, structured
// so the write and read halves can later be split into separate domains.
module async_fifo_core
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] w_data,
    input  logic                 w_en,
    output logic                 w_full,
    input  logic                 r_en,
    output logic [DATA_SIZE-1:0] r_data,
    output logic                 r_empty
);

    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam int PTR_W = ADDR_SIZE + 1;

    logic [DATA_SIZE-1:0] mem_r [0:DEPTH-1];

    logic [PTR_W-1:0] wbin_r,  wgray_r;
    logic [PTR_W-1:0] rbin_r,  rgray_r;
    logic             w_full_r, r_empty_r;

    logic             w_inc_s, r_inc_s;
    logic [PTR_W-1:0] wbin_next_s, wgray_next_s;
    logic [PTR_W-1:0] rbin_next_s, rgray_next_s;
    logic [PTR_W-1:0] wq2_wgray_s, rq2_rgray_s;
    logic [PTR_W-1:0] full_cmp_s;

    fifo_sync_2ff #(.WIDTH(PTR_W)) u_sync_w2r (
        .clk (clk),
        .rst (rst),
        .d   (wgray_r),
        .q   (wq2_wgray_s)
    );

    fifo_sync_2ff #(.WIDTH(PTR_W)) u_sync_r2w (
        .clk (clk),
        .rst (rst),
        .d   (rgray_r),
        .q   (rq2_rgray_s)
    );

    // Next-pointer and flag-comparison logic for both sides.
    always_comb begin
        w_inc_s = 1'b0;
        r_inc_s = 1'b0;
        if (!rst && w_en && !w_full_r) begin
            w_inc_s = 1'b1;
        end else begin
            w_inc_s = 1'b0;
        end
        if (!rst && r_en && !r_empty_r) begin
            r_inc_s = 1'b1;
        end else begin
            r_inc_s = 1'b0;
        end
        wbin_next_s  = wbin_r + PTR_W'(w_inc_s);
        rbin_next_s  = rbin_r + PTR_W'(r_inc_s);
        wgray_next_s = PTR_W'(bin2gray(32'(wbin_next_s)));
        rgray_next_s = PTR_W'(bin2gray(32'(rbin_next_s)));
        // Full when write pointer is one lap ahead: top two Gray bits inverted.
        full_cmp_s   = {~rq2_rgray_s[ADDR_SIZE:ADDR_SIZE-1], rq2_rgray_s[ADDR_SIZE-2:0]};
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_inc_s) begin
            mem_r[wbin_r[ADDR_SIZE-1:0]] <= w_data;
        end
    end

    // Pointer and flag registers for both sides.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_r    <= {PTR_W{1'b0}};
            wgray_r   <= {PTR_W{1'b0}};
            rbin_r    <= {PTR_W{1'b0}};
            rgray_r   <= {PTR_W{1'b0}};
            w_full_r  <= 1'b0;
            r_empty_r <= 1'b1;
        end else begin
            wbin_r    <= wbin_next_s;
            wgray_r   <= wgray_next_s;
            rbin_r    <= rbin_next_s;
            rgray_r   <= rgray_next_s;
            w_full_r  <= (wgray_next_s == full_cmp_s);
            r_empty_r <= (rgray_next_s == wq2_wgray_s);
        end
    end

    // Show-ahead: head word is visible as soon as the read pointer moves.
    assign r_data  = mem_r[rbin_r[ADDR_SIZE-1:0]];
    assign w_full  = w_full_r;
    assign r_empty = r_empty_r;

endmodule

// File: tb/tb_async_fifo_core.sv
// Scoreboard bench: accepted writes queue their expected word, a negedge
// monitor pops and compares whenever a read is about to be taken.
module tb_async_fifo_core;

    logic        clk;
    logic        rst;
    logic [31:0] w_data;
    logic        w_en;
    logic        w_full;
    logic        r_en;
    logic [31:0] r_data;
    logic        r_empty;

    int          checks;
    int          errors;
    logic [31:0] exp_q [$];
    logic [31:0] last_pop;

    async_fifo_core dut (
        .clk     (clk),
        .rst     (rst),
        .w_data  (w_data),
        .w_en    (w_en),
        .w_full  (w_full),
        .r_en    (r_en),
        .r_data  (r_data),
        .r_empty (r_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a read happens at the next rising edge, compare head word now.
    always @(negedge clk) begin
        if (!rst && r_en && !r_empty) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %0h expected no read", r_data);
            end else begin
                last_pop = exp_q.pop_front();
                if (r_data !== last_pop) begin
                    errors++;
                    $display("FAIL rd_data: got %0h expected %0h", r_data, last_pop);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [31:0] base, input int n, input bit push);
        w_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            w_data = base + 32'(i);
            if (push) exp_q.push_back(w_data);
            tick();
        end
        w_en = 1'b0;
    endtask

    task automatic wait_not_empty(input string name);
        int i;
        for (i = 0; i < 20; i++) begin
            if (!r_empty) break;
            tick();
        end
        check(name, {31'd0, r_empty}, 32'd0);
    endtask

    task automatic drain(input string name);
        int i;
        r_en = 1'b1;
        for (i = 0; i < 1000; i++) begin
            tick();
            if (exp_q.size() == 0) break;
        end
        r_en = 1'b0;
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_empty"}, {31'd0, r_empty}, 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        w_en   = 1'b0;
        r_en   = 1'b0;
        w_data = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_empty", {31'd0, r_empty}, 32'd1);
        check("rst_full",  {31'd0, w_full},  32'd0);
        r_en = 1'b1;
        tick();
        tick();
        r_en = 1'b0;
        check("rd_on_empty", {31'd0, r_empty}, 32'd1);

        // Basic order with empty-flag latency.
        w_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_data = 32'(i);
            exp_q.push_back(w_data);
            tick();
            if (i == 2) check("empty_at_k2", {31'd0, r_empty}, 32'd1);
            if (i == 3) check("empty_at_k3", {31'd0, r_empty}, 32'd0);
        end
        w_en = 1'b0;
        tick();
        tick();
        tick();
        r_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        r_en = 1'b0;
        check("basic_left",  32'(exp_q.size()), 32'd0);
        check("basic_empty", {31'd0, r_empty}, 32'd1);
        write_burst(32'h0000_00A5, 1, 1'b1);
        wait_not_empty("a5_visible");
        drain("a5");

        // Fill: 256 accepted, 257th and 258th dropped.
        tick();
        tick();
        tick();
        w_en = 1'b1;
        for (int i = 0; i < 258; i++) begin
            w_data = 32'(i);
            if (i < 256) exp_q.push_back(w_data);
            tick();
            if (i == 254) check("full_at_255", {31'd0, w_full}, 32'd0);
            if (i == 255) check("full_at_256", {31'd0, w_full}, 32'd1);
            if (i == 257) check("full_held",   {31'd0, w_full}, 32'd1);
        end
        w_en = 1'b0;
        drain("fill");
        tick();
        tick();
        tick();
        check("full_released", {31'd0, w_full}, 32'd0);

        // Wrap-around in bursts of 100.
        for (int b = 0; b < 3; b++) begin
            write_burst(32'd1000 + 32'(b * 100), 100, 1'b1);
            tick();
            tick();
            tick();
            check("wrap_not_full", {31'd0, w_full}, 32'd0);
            drain("wrap");
        end

        // Concurrent access at occupancy 10.
        write_burst(32'd2000, 10, 1'b1);
        tick();
        tick();
        tick();
        w_en = 1'b1;
        r_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            w_data = 32'd2010 + 32'(i);
            exp_q.push_back(w_data);
            tick();
        end
        w_en = 1'b0;
        r_en = 1'b0;
        check("conc_occupancy", 32'(exp_q.size()), 32'd10);
        check("conc_not_full",  {31'd0, w_full},  32'd0);
        tick();
        tick();
        tick();
        drain("conc");

        // Mid-operation reset discards contents; enables during rst ignored.
        write_burst(32'd3000, 20, 1'b0);
        tick();
        tick();
        tick();
        rst    = 1'b1;
        w_en   = 1'b1;
        r_en   = 1'b1;
        w_data = 32'hDEAD_BEEF;
        tick();
        rst  = 1'b0;
        w_en = 1'b0;
        r_en = 1'b0;
        check("midrst_empty", {31'd0, r_empty}, 32'd1);
        check("midrst_full",  {31'd0, w_full},  32'd0);
        tick();
        check("midrst_empty2", {31'd0, r_empty}, 32'd1);
        write_burst(32'h0000_1234, 1, 1'b1);
        wait_not_empty("r1234_visible");
        drain("r1234");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
